// File: rtl/i2s_master_if.sv
// Frame-write handshake and I2S serial pins of the I2S transmitter.
// master: the transmitter side; slave: the frame producer / I2S receiver side.
interface i2s_master_if;
    logic [47:0] frame_in;
    logic        write_frame;
    logic        full;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    modport master (
        input  frame_in, write_frame,
        output full, bclk, lrclk, sdata
    );

    modport slave (
        output frame_in, write_frame,
        input  full, bclk, lrclk, sdata
    );
endinterface

// File: rtl/i2s_master.sv
// I2S transmitter: frame FIFO feeding a 48-bit shift register.
// Serialises 24-bit left/right samples MSB first, with no bit delay after lrclk.
module i2s_master #(
    parameter int CLK_DIV    = 26,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk_soc,
    input  logic          reset,
    i2s_master_if.master  bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] div_cnt;
    logic          bclk_q;
    logic          lrclk_q;
    logic          sdata_q;
    logic          full_q;
    logic [5:0]    bit_cnt;
    logic [47:0]   shreg;

    logic [47:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;

    logic          tick;
    logic          rise;
    logic          frame_start;
    logic          push;
    logic          pop;
    logic [47:0]   load_word;

    assign tick        = (div_cnt == DW'(CLK_DIV - 1));
    assign rise        = tick && !bclk_q;
    assign frame_start = rise && (bit_cnt == 6'd0);
    assign push        = bus.write_frame && !full_q;
    assign pop         = frame_start && (count != '0);
    // An empty FIFO at frame start sends silence; a same-cycle write waits for the next frame.
    assign load_word   = (count != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk_soc) begin
        if (push)
            mem[wr_ptr] <= bus.frame_in;
    end

    always_ff @(posedge clk_soc or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b1;
            sdata_q <= 1'b0;
            full_q  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                bclk_q <= !bclk_q;

            // lrclk and sdata move only with the bclk rise, so they are settled at every fall.
            if (rise) begin
                bit_cnt <= (bit_cnt == 6'd47) ? 6'd0 : bit_cnt + 1'b1;
                lrclk_q <= (bit_cnt >= 6'd24);
                if (frame_start) begin
                    sdata_q <= load_word[47];
                    shreg   <= {load_word[46:0], 1'b0};
                end else begin
                    sdata_q <= shreg[47];
                    shreg   <= {shreg[46:0], 1'b0};
                end
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == (AW+1)'(FIFO_DEPTH));
        end
    end

    assign bus.bclk  = bclk_q;
    assign bus.lrclk = lrclk_q;
    assign bus.sdata = sdata_q;
    assign bus.full  = full_q;
endmodule

// File: tb/tb_i2s_master.sv
// Self-checking bench for i2s_master: table-driven playback plus directed corner sequences.
// A forked receiver samples sdata on bclk falling edges and reassembles frames.
module tb_i2s_master;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_CYC  = 96 * CLK_DIV;

    typedef struct {
        bit          wr;
        logic [47:0] din;
        logic [47:0] exp;
    } vec_t;

    logic clk_soc = 1'b0;
    logic reset   = 1'b0;

    i2s_master_if bus ();

    i2s_master #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_soc(clk_soc),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_soc = ~clk_soc;

    int          checks   = 0;
    int          failures = 0;
    logic [47:0] rx_q [$];
    logic [47:0] exp_q [$];
    bit          framing_en = 1'b0;

    int          cyc = 0;
    int          last_fall = -1;
    int          phase_cnt = 0;
    int          bits = 0;
    logic        rx_lr = 1'b1;
    logic [47:0] rx_word = '0;
    logic        pb = 1'b0;
    logic        plr = 1'b1;
    logic        psd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_soc);
            cyc++;
            if (!reset) begin
                rx_lr     = 1'b1;
                phase_cnt = 0;
                bits      = 0;
                last_fall = -1;
            end else begin
                if (bus.lrclk !== plr || bus.sdata !== psd)
                    check("change_only_on_bclk_rise", 64'({pb, bus.bclk}), 64'b01);
                if (pb && !bus.bclk) begin
                    if (bus.lrclk !== rx_lr) begin
                        if (framing_en && phase_cnt != 0)
                            check("falls_per_phase", 64'(phase_cnt), 64'd24);
                        phase_cnt = 0;
                        if (!bus.lrclk) begin
                            bits = 0;
                            if (framing_en && last_fall >= 0)
                                check("lrclk_period", 64'(cyc - last_fall), 64'(FRAME_CYC));
                            last_fall = cyc;
                        end
                    end
                    rx_word = {rx_word[46:0], bus.sdata};
                    bits++;
                    phase_cnt++;
                    rx_lr = bus.lrclk;
                    if (bits == 48)
                        rx_q.push_back(rx_word);
                end
            end
            pb  = bus.bclk;
            plr = bus.lrclk;
            psd = bus.sdata;
        end
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.write_frame = 1'b0;
        bus.frame_in    = '0;
        repeat (3) @(posedge clk_soc);
        #1;
        check("rst_bclk",  64'(bus.bclk),  64'd0);
        check("rst_lrclk", 64'(bus.lrclk), 64'd1);
        check("rst_sdata", 64'(bus.sdata), 64'd0);
        check("rst_full",  64'(bus.full),  64'd0);
        rx_q.delete();
        framing_en = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (rx_q.size() < n && c < (n + 2) * FRAME_CYC) begin
            @(posedge clk_soc);
            c++;
        end
        #1;
        check("frames_received", 64'(rx_q.size() >= n), 64'd1);
    endtask

    vec_t vecs [5];
    int   n;

    initial begin
        bus.frame_in    = '0;
        bus.write_frame = 1'b0;
        fork
            monitor();
        join_none

        // Ordered playback from reset; fifth frame must be silence.
        vecs[0] = '{1'b1, 48'h123456_abcdef, 48'h123456_abcdef};
        vecs[1] = '{1'b1, 48'h111111_222222, 48'h111111_222222};
        vecs[2] = '{1'b1, 48'h333333_444444, 48'h333333_444444};
        vecs[3] = '{1'b1, 48'h555555_666666, 48'h555555_666666};
        vecs[4] = '{1'b0, 48'h0,             48'h0};
        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus.write_frame = 1'b1;
                bus.frame_in    = vecs[i].din;
                @(posedge clk_soc);
                #1;
            end
        end
        bus.write_frame = 1'b0;
        wait_frames(5);
        foreach (vecs[i])
            check($sformatf("playback_%0d", i), 64'(rx_q[i]), 64'(vecs[i].exp));

        // First rise CLK_DIV edges after release, starting frame 0; then 10 frames of framing.
        do_reset();
        n = 0;
        while (!bus.bclk && n < 100) begin
            @(posedge clk_soc);
            #1;
            n++;
        end
        check("first_rise_delay", 64'(n), 64'(CLK_DIV));
        check("lrclk_frame0", 64'(bus.lrclk), 64'd0);
        framing_en = 1'b1;
        wait_frames(10);
        framing_en = 1'b0;

        // Fill while writing every cycle. With CLK_DIV < FIFO_DEPTH the first frame
        // start pops one entry during the fill, so one extra write is accepted.
        do_reset();
        bus.write_frame = 1'b1;
        bus.frame_in    = 48'hffffff_ffffff;
        n = 0;
        while (!bus.full && n < 10000) begin
            @(posedge clk_soc);
            #1;
            n++;
        end
        bus.write_frame = 1'b0;
        check("writes_to_full", 64'(n), 64'(FIFO_DEPTH + 1));
        check("full_flag", 64'(bus.full), 64'd1);

        // Overflow: the write made while full must never play.
        do_reset();
        exp_q.delete();
        bus.write_frame = 1'b1;
        n = 0;
        while (!bus.full && n < 100) begin
            bus.frame_in = {24'h100000 + 24'(n), 24'h200000 + 24'(n)};
            @(posedge clk_soc);
            #1;
            exp_q.push_back(bus.frame_in);
            n++;
        end
        bus.frame_in = 48'h000001_000002;
        @(posedge clk_soc);
        #1;
        bus.write_frame = 1'b0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        wait_frames(exp_q.size());
        foreach (exp_q[i])
            check($sformatf("overflow_frame_%0d", i), 64'(rx_q[i]), 64'(exp_q[i]));

        // Reset during a right-channel '1' bit; FIFO contents must be dropped.
        do_reset();
        bus.write_frame = 1'b1;
        bus.frame_in    = 48'h123456_abcdef;
        @(posedge clk_soc); #1;
        bus.frame_in    = 48'h111111_222222;
        @(posedge clk_soc); #1;
        bus.frame_in    = 48'h333333_444444;
        @(posedge clk_soc); #1;
        bus.write_frame = 1'b0;
        n = 0;
        while (!(bus.lrclk && bus.bclk && bus.sdata) && n < 2 * FRAME_CYC) begin
            @(posedge clk_soc);
            #1;
            n++;
        end
        check("right_bit_reached", 64'(bus.lrclk && bus.bclk && bus.sdata), 64'd1);
        reset = 1'b0;
        #1;
        check("async_bclk",  64'(bus.bclk),  64'd0);
        check("async_lrclk", 64'(bus.lrclk), 64'd1);
        check("async_sdata", 64'(bus.sdata), 64'd0);
        check("async_full",  64'(bus.full),  64'd0);
        do_reset();
        wait_frames(2);
        check("post_reset_frame0", 64'(rx_q[0]), 64'd0);
        check("post_reset_frame1", 64'(rx_q[1]), 64'd0);

        // Write lands exactly on the first frame-load edge with the FIFO empty.
        do_reset();
        repeat (CLK_DIV - 1) begin
            @(posedge clk_soc);
            #1;
        end
        bus.write_frame = 1'b1;
        bus.frame_in    = 48'h0a0b0c_0d0e0f;
        @(posedge clk_soc);
        #1;
        bus.write_frame = 1'b0;
        check("collision_on_load_edge", 64'(bus.bclk), 64'd1);
        wait_frames(3);
        check("collision_frame0", 64'(rx_q[0]), 64'd0);
        check("collision_frame1", 64'(rx_q[1]), 64'h0a0b0c_0d0e0f);
        check("collision_frame2", 64'(rx_q[2]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_master.md
I2S_MASTER -- requirements
Module: i2s_master

Interface
REQ-001 Parameter CLK_DIV, default 26: clk_soc cycles per BCLK half-period; minimum 2.
REQ-002 Parameter FIFO_DEPTH, default 16: frame FIFO entries; power of two, at least 4.
REQ-003 Port clk_soc, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 Port frame_in, input, 48 bits: frame to enqueue; [47:24] is the left sample, [23:0] is the right sample.
REQ-006 Port write_frame, input, 1 bit: enqueue frame_in at this clk_soc edge.
REQ-007 Port full, output, 1 bit: FIFO holds FIFO_DEPTH frames.
REQ-008 Port bclk, output, 1 bit: I2S bit clock.
REQ-009 Port lrclk, output, 1 bit: word select; 0 = left, 1 = right.
REQ-010 Port sdata, output, 1 bit: serial data, MSB first.

Function
REQ-011 bclk, lrclk, sdata and full SHALL be registered outputs driven directly by flip-flops (glitch-free).
REQ-012 bclk SHALL toggle every CLK_DIV clk_soc cycles while out of reset; it is free-running with a 50% duty cycle.
REQ-013 lrclk and sdata SHALL change only in the cycle in which bclk rises; they are stable across every bclk falling edge, where the receiver samples.
REQ-014 A frame SHALL be 48 bclk periods: 24 with lrclk=0 (left), then 24 with lrclk=1 (right); lrclk falls at frame start.
REQ-015 Left bits 23..0 SHALL be driven on the 24 rising edges starting at the edge where lrclk falls; right bits 23..0 start at the edge where lrclk rises.
REQ-016 No bit delay; exactly 24 bclk falling edges SHALL occur per lrclk phase.
REQ-017 Frame load: in the bclk-rising cycle that starts a frame, a non-empty FIFO SHALL have its head popped into a 48-bit shift register; an empty FIFO loads all zeros.
REQ-018 FIFO is a synchronous FIFO with order preserved; a write SHALL be accepted when write_frame=1 and full=0, and ignored when full=1 (frame discarded, no state change).
REQ-019 full SHALL reflect occupancy one cycle after the update; a simultaneous write and pop leaves occupancy unchanged.
REQ-020 A write in the same cycle as a frame load with an empty FIFO SHALL be stored; zeros are sent for that frame and the written frame in the following frame.
REQ-021 Write-to-output latency: a frame written while the FIFO is empty SHALL appear at the next frame start.
REQ-022 Sustained 48 kHz output at clk_soc=120 MHz, CLK_DIV=26 (frame = 2496 cycles, 20.8 us).

Reset
REQ-023 While reset=0, the following SHALL hold:
- bclk=0, lrclk=1, sdata=0, full=0
- FIFO empty, shift register zero, divider and bit counters zero
REQ-024 Asserting reset mid-frame SHALL:
- abort the frame immediately
- discard all FIFO contents
REQ-025 After reset deasserts, the first bclk rise SHALL occur CLK_DIV cycles later; that rise starts frame 0, with lrclk falling.
REQ-026 Writes SHALL be accepted from the first clock edge after deassertion.

Verification
REQ-027 Ordered playback: reset, then write 123456_abcdef, 111111_222222, 333333_444444, 555555_666666 on consecutive cycles -> the first four frames sampled on bclk falling edges are L/R 123456/abcdef, 111111/222222, 333333/444444, 555555/666666, and the fifth frame is 000000/000000.
REQ-028 Framing: count bclk falling edges per lrclk phase over 10 frames -> exactly 24 per phase; lrclk period = 48*2*CLK_DIV clk_soc cycles.
REQ-029 Full flag: write ffffff_ffffff every cycle after reset -> full rises after exactly FIFO_DEPTH accepted writes (16), well within 10000 cycles.
REQ-030 Overflow discard: fill the FIFO with 16 distinct frames plus a 17th (000001_000002) -> the 16 frames play in order, then zeros; 000001/000002 never appears.
REQ-031 Reset mid-frame: pull reset low during a right-channel bit -> outputs reach reset values asynchronously, and after release only zero frames play until a new write.
REQ-032 Empty/write collision: write 0a0b0c_0d0e0f in the frame-load cycle with the FIFO empty -> the current frame is zeros and the next frame is 0a0b0c/0d0e0f.
